// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD front end: sequencer states,
// wake-up nibbles and the default timing used by both the init sequencer
// and the command write controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPwr,
    StSetup,
    StPulse,
    StHold,
    StWaitStep,
    StDone
  } lcd_state_e;

  localparam logic [3:0] LCD_WAKE = 4'h3;
  localparam logic [3:0] LCD_4BIT = 4'h2;

  // Default timing at 50 MHz.
  localparam int unsigned LCD_T_POWERUP = 750000;
  localparam int unsigned LCD_T_WAIT1   = 205000;
  localparam int unsigned LCD_T_WAIT2   = 5000;
  localparam int unsigned LCD_T_WAIT34  = 2000;
  localparam int unsigned LCD_T_SETUP   = 2;
  localparam int unsigned LCD_T_E_HIGH  = 12;
  localparam int unsigned LCD_CNT_W     = 20;

  // Wake-up nibble for a given write step: three 0x3 writes, then 0x2.
  function automatic logic [3:0] lcd_nibble(input logic [1:0] step);
    return (step == 2'd3) ? LCD_4BIT : LCD_WAKE;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Reloadable delay timer. Counts up while enabled and flags the last cycle
// of a target-length interval; dropping enable clears the count.
module lcd_delay_timer #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] target,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Count while enabled, clear otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!enable) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + ONE;
    end
  end

  // Last cycle of the interval; independent of enable to avoid a loop with the FSM.
  assign tick = (cnt_q == (target - ONE));

endmodule

// File: rtl/lcd_init_sequencer.sv
// Power-on wake-up sequencer for a 4-bit character LCD. Issues the four
// fixed nibble writes with the required waits, then holds init_done.
module lcd_init_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = LCD_T_POWERUP,
  parameter int unsigned T_WAIT1   = LCD_T_WAIT1,
  parameter int unsigned T_WAIT2   = LCD_T_WAIT2,
  parameter int unsigned T_WAIT34  = LCD_T_WAIT34,
  parameter int unsigned T_SETUP   = LCD_T_SETUP,
  parameter int unsigned T_E_HIGH  = LCD_T_E_HIGH,
  parameter int unsigned CNT_W     = LCD_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] lcd_sf_d,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       busy,
  output logic       init_done
);

  localparam logic [CNT_W-1:0] TGT_PWR   = CNT_W'(T_POWERUP);
  localparam logic [CNT_W-1:0] TGT_W1    = CNT_W'(T_WAIT1);
  localparam logic [CNT_W-1:0] TGT_W2    = CNT_W'(T_WAIT2);
  localparam logic [CNT_W-1:0] TGT_W34   = CNT_W'(T_WAIT34);
  localparam logic [CNT_W-1:0] TGT_SETUP = CNT_W'(T_SETUP);
  localparam logic [CNT_W-1:0] TGT_EHIGH = CNT_W'(T_E_HIGH);
  localparam logic [CNT_W-1:0] TGT_HOLD  = CNT_W'(1);

  lcd_state_e       state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] target;
  logic             timed;
  logic             enable;
  logic             tick;

  logic [3:0]       sf_d_q, sf_d_d;
  logic             e_q, e_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Interval length of the current state.
  always_comb begin
    target = '0;
    case (state_q)
      StWaitPwr:  target = TGT_PWR;
      StSetup:    target = TGT_SETUP;
      StPulse:    target = TGT_EHIGH;
      StHold:     target = TGT_HOLD;
      StWaitStep: begin
        case (step_q)
          2'd0:    target = TGT_W1;
          2'd1:    target = TGT_W2;
          default: target = TGT_W34;
        endcase
      end
      default:    target = '0;
    endcase
  end

  // Timer runs only in timed states and is held clear on the exit cycle, so
  // every state starts with a zero count.
  always_comb begin
    timed  = (state_q == StWaitPwr) || (state_q == StSetup) || (state_q == StPulse) ||
             (state_q == StHold) || (state_q == StWaitStep);
    enable = timed && !tick;
  end

  lcd_delay_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .target (target),
    .tick   (tick)
  );

  // Next-state and step sequencing.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitPwr;
          step_d  = 2'd0;
        end
      end
      StWaitPwr: begin
        if (tick) begin
          state_d = StSetup;
          step_d  = 2'd0;
        end
      end
      StSetup: begin
        if (tick) state_d = StPulse;
      end
      StPulse: begin
        if (tick) state_d = StHold;
      end
      StHold: begin
        if (tick) state_d = StWaitStep;
      end
      StWaitStep: begin
        if (tick) begin
          if (step_q == 2'd3) begin
            state_d = StDone;
          end else begin
            state_d = StSetup;
            step_d  = step_q + 2'd1;
          end
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    sf_d_d = 4'h0;
    if ((state_d == StSetup) || (state_d == StPulse) || (state_d == StHold)) begin
      sf_d_d = lcd_nibble(step_d);
    end
    e_d    = (state_d == StPulse);
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      step_q  <= 2'd0;
      sf_d_q  <= 4'h0;
      e_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sf_d_q  <= sf_d_d;
      e_q     <= e_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign lcd_sf_d  = sf_d_q;
  assign lcd_e     = e_q;
  // Init only writes instructions, never reads.
  assign lcd_rs    = 1'b0;
  assign lcd_rw    = 1'b0;
  assign busy      = busy_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer with reduced timing. A per-cycle expected
// output trace is built from the write/wait schedule and compared each cycle.
module tb_lcd_init_sequencer;

  localparam int unsigned TP   = 20;
  localparam int unsigned TW1  = 10;
  localparam int unsigned TW2  = 5;
  localparam int unsigned TW34 = 3;
  localparam int unsigned TS   = 1;
  localparam int unsigned TE   = 2;
  localparam int unsigned CW   = 20;
  localparam int unsigned DUR  = TP + 4 * (TS + TE + 1) + TW1 + TW2 + 2 * TW34;
  // Trace index of the first high cycle of the second enable pulse.
  localparam int unsigned P2   = TP + (TS + TE + 1) + TW1 + TS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] lcd_sf_d;
  logic       lcd_e, lcd_rs, lcd_rw, busy, init_done;

  always #5 clk = ~clk;

  lcd_init_sequencer #(
    .T_POWERUP (TP),
    .T_WAIT1   (TW1),
    .T_WAIT2   (TW2),
    .T_WAIT34  (TW34),
    .T_SETUP   (TS),
    .T_E_HIGH  (TE),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lcd_sf_d  (lcd_sf_d),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .busy      (busy),
    .init_done (init_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Expected {nibble, e} for each busy cycle of a sequence.
  logic [4:0] trace[$];
  logic [3:0] nibs[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
  int         waits[4] = '{TW1, TW2, TW34, TW34};

  // Reference model: 0 idle, 1 running at trace index m_idx, 2 done.
  int m_mode = 0;
  int m_idx  = 0;

  // Monitors.
  int         cyc = 0;
  int         busy_rise = 0;
  int         e_w = 0;
  logic       busy_p = 1'b0, done_p = 1'b0, e_p = 1'b0;
  logic [3:0] pulses[$];

  function automatic logic [8:0] exp_vec();
    logic [8:0] v;
    v = 9'h0;
    if (m_mode == 1 && m_idx < trace.size()) v = {trace[m_idx], 2'b00, 1'b1, 1'b0};
    else if (m_mode == 2) v = 9'b0_0000_0001;
    return v;
  endfunction

  task automatic step(input logic rst, input logic st);
    @(negedge clk);
    reset = rst;
    start = st;
    @(posedge clk);
    if (!rst) begin
      m_mode = 0;
      m_idx  = 0;
    end else if (m_mode == 0) begin
      if (st) begin
        m_mode = 1;
        m_idx  = 0;
      end
    end else if (m_mode == 1) begin
      m_idx++;
      if (m_idx == int'(DUR)) m_mode = 2;
    end
    #1;
    cyc++;
    check_eq("outputs", 32'({lcd_sf_d, lcd_e, lcd_rs, lcd_rw, busy, init_done}), 32'(exp_vec()));
    if (busy && !busy_p) begin
      busy_rise = cyc;
      pulses.delete();
    end
    if (init_done && !done_p) begin
      check_eq("duration", 32'(cyc - busy_rise), 32'(DUR));
      check_eq("npulse", 32'(pulses.size()), 32'd4);
      for (int k = 0; k < pulses.size() && k < 4; k++) begin
        check_eq("nibble", 32'(pulses[k]), 32'(nibs[k]));
      end
    end
    if (lcd_e && !e_p) begin
      pulses.push_back(lcd_sf_d);
      e_w = 0;
    end
    if (lcd_e) e_w++;
    if (!lcd_e && e_p && rst) check_eq("e_width", 32'(e_w), 32'(TE));
    busy_p = busy;
    done_p = init_done;
    e_p    = lcd_e;
  endtask

  // smode: 0 = single start pulse, 1 = start held, 2 = random extra starts.
  task automatic run_seq(input int smode);
    logic st;
    step(1'b1, 1'b1);
    for (int g = 0; g < int'(DUR) + 20; g++) begin
      if (m_mode == 2) break;
      st = (smode == 0) ? 1'b0 : (smode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      step(1'b1, st);
    end
    check_eq("seq_done", 32'(init_done), 32'd1);
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < int'(TS); i++) trace.push_back({nibs[s], 1'b0});
      for (int i = 0; i < int'(TE); i++) trace.push_back({nibs[s], 1'b1});
      trace.push_back({nibs[s], 1'b0});
      for (int i = 0; i < waits[s]; i++) trace.push_back(5'h0);
    end
    for (int i = 0; i < int'(TP); i++) trace.push_front(5'h0);

    repeat (3) step(1'b0, 1'b1);
    check_eq("reset_state", 32'({lcd_sf_d, lcd_e, lcd_rs, lcd_rw, busy, init_done}), 32'd0);
    step(1'b1, 1'b0);
    check_eq("idle_no_start", 32'(busy), 32'd0);

    // Single start pulse, then start toggled after completion.
    run_seq(0);
    repeat (100) step(1'b1, 1'($urandom_range(0, 1)));
    check_eq("done_sticky", 32'({busy, init_done, lcd_e}), 32'b010);

    // Start held high throughout.
    step(1'b0, 1'b0);
    run_seq(1);

    // Random extra start pulses mid-sequence.
    step(1'b0, 1'b0);
    run_seq(2);

    // Reset during the second enable pulse.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int g = 0; g < 200 && !(m_mode == 1 && m_idx == int'(P2)); g++) step(1'b1, 1'b0);
    check_eq("pulse2_e", 32'({lcd_e, lcd_sf_d}), 32'h13);
    step(1'b0, 1'b0);
    check_eq("rst_mid", 32'({lcd_sf_d, lcd_e, lcd_rs, lcd_rw, busy, init_done}), 32'd0);
    run_seq(0);

    // Random start/abort rounds.
    for (int r = 0; r < 6; r++) begin
      int k;
      k = $urandom_range(1, DUR + 5);
      step(1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      repeat (k) step(1'b1, 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0);
    run_seq(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
